// File: rtl/cordic_arb_pkg.sv
// Shared types for the cordic round-robin front end: sequencer states,
// the captured result bundle and the engine angle width.
package cordic_arb_pkg;

    localparam int ANGLE_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_SETTLE = 3'd2,
        ST_WAIT   = 3'd3,
        ST_HOLD   = 3'd4
    } arb_state_t;

    typedef struct packed {
        logic [ANGLE_W-1:0] sin;
        logic [ANGLE_W-1:0] cos;
        logic [ANGLE_W-1:0] tan;
        logic [ANGLE_W-1:0] cot;
    } cordic_result_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request picker: one-hot grant plus index, pointer moves to
// the slot after the winner whenever the caller takes the grant.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic                 advance,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx
);

    localparam int             IDX_W = $clog2(N);
    localparam logic [IDX_W:0] W_N   = (IDX_W+1)'(N);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W:0]   w_cand;
    logic             w_found;

    // Forward search from the pointer, wrapping past N-1 back to 0.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        w_cand    = '0;
        for (int k = 0; k < N; k++) begin
            w_cand = {1'b0, r_ptr} + (IDX_W+1)'(k);
            if (w_cand >= W_N) begin
                w_cand = w_cand - W_N;
            end else begin
                w_cand = w_cand;
            end
            if (!w_found && req[w_cand[IDX_W-1:0]]) begin
                w_found                   = 1'b1;
                grant_idx                 = w_cand[IDX_W-1:0];
                grant[w_cand[IDX_W-1:0]]  = 1'b1;
            end else begin
                w_found = w_found;
            end
        end
    end

    // Priority pointer update on an accepted grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (advance && w_found) begin
            if (grant_idx == IDX_W'(N - 1)) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= grant_idx + IDX_W'(1);
            end
        end else begin
            r_ptr <= r_ptr;
        end
    end

endmodule

// File: rtl/cordic_arbiter.sv
// Shares one cordic engine among NUM_REQ requesters; sequences the engine
// reset pulse and holds each result until taken. Watchdog: CORDIC_ARB_TIMEOUT_EN.
module cordic_arbiter
    import cordic_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [16*NUM_REQ-1:0]      req_angle,
    input  logic [NUM_REQ-1:0]         req_radian,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [15:0]                rsp_sin,
    output logic [15:0]                rsp_cos,
    output logic [15:0]                rsp_tan,
    output logic [15:0]                rsp_cot,
    output logic                       rsp_timeout,
    output logic                       core_rst,
    output logic [15:0]                core_angle,
    output logic                       core_radian_en,
    input  logic [15:0]                core_sin,
    input  logic [15:0]                core_cos,
    input  logic [15:0]                core_tan,
    input  logic [15:0]                core_cot,
    input  logic                       core_done,
    output logic                       busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t         r_state;
    cordic_result_t     r_result;
    logic               r_rsp_valid;
    logic               r_core_rst;
    logic               r_core_radian;
    logic               r_busy;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   r_rsp_id;
    logic [ANGLE_W-1:0] r_core_angle;

    logic [NUM_REQ-1:0] w_grant;
    logic [IDX_W-1:0]   w_grant_idx;
    logic               w_in_idle;
    logic               w_take;
    logic [ANGLE_W-1:0] w_sel_angle;

`ifdef CORDIC_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] r_wait_cnt;
    logic             r_rsp_timeout;
    assign rsp_timeout = r_rsp_timeout;
`else
    assign rsp_timeout = 1'b0;
`endif

    // The grant is only offered while idle and never during reset.
    assign w_in_idle   = (r_state == ST_IDLE) && !rst;
    assign w_take      = w_in_idle && (|w_grant);
    assign req_ready   = w_in_idle ? w_grant : '0;
    assign w_sel_angle = req_angle[w_grant_idx*ANGLE_W +: ANGLE_W];

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .advance   (w_in_idle),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    // Sequencer: latch operands, pulse engine reset, wait for done, hold result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_result      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_id      <= '0;
            r_owner       <= '0;
            r_core_rst    <= 1'b1;
            r_core_angle  <= '0;
            r_core_radian <= 1'b0;
            r_busy        <= 1'b0;
`ifdef CORDIC_ARB_TIMEOUT_EN
            r_wait_cnt    <= '0;
            r_rsp_timeout <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_take) begin
                        r_owner       <= w_grant_idx;
                        r_core_angle  <= w_sel_angle;
                        r_core_radian <= req_radian[w_grant_idx];
                        r_busy        <= 1'b1;
                        r_state       <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    r_core_rst <= 1'b0;
                    r_state    <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    // done may still reflect the previous run here, so it is ignored
`ifdef CORDIC_ARB_TIMEOUT_EN
                    r_wait_cnt <= '0;
`endif
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (core_done) begin
                        r_result.sin <= core_sin;
                        r_result.cos <= core_cos;
                        r_result.tan <= core_tan;
                        r_result.cot <= core_cot;
                        r_rsp_id     <= r_owner;
                        r_rsp_valid  <= 1'b1;
                        r_core_rst   <= 1'b1;
                        r_state      <= ST_HOLD;
`ifdef CORDIC_ARB_TIMEOUT_EN
                        r_rsp_timeout <= 1'b0;
                    end else if (r_wait_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        r_result      <= '0;
                        r_rsp_id      <= r_owner;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_core_rst    <= 1'b1;
                        r_state       <= ST_HOLD;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + TMO_W'(1);
`endif
                    end
                end
                ST_HOLD: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_core_rst  <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid      = r_rsp_valid;
    assign rsp_id         = r_rsp_id;
    assign rsp_sin        = r_result.sin;
    assign rsp_cos        = r_result.cos;
    assign rsp_tan        = r_result.tan;
    assign rsp_cot        = r_result.cot;
    assign core_rst       = r_core_rst;
    assign core_angle     = r_core_angle;
    assign core_radian_en = r_core_radian;
    assign busy           = r_busy;

endmodule
